timer_cmd_sequencer: RTL and testbench
======================================

// Module: timer_cmd_sequencer
// PURPOSE
//  Upstream command stage for the countdown timer. Buffers load values from a
//  valid/ready producer in a small FIFO and issues them one at a time as a
//  single-cycle start pulse plus load_val. Waits for the timer's done before
//  issuing the next; guarantees start is never high while done is.
//  A watchdog aborts a command whose done never arrives.
// PARAMETERS
//  W        4   width of load value (matches timer count width)
//  DEPTH    4   command FIFO entries (power of 2, >=2)
//  TIMEOUT  20  max WAIT cycles before abort (> 2^W)
// PORTS
//  clk          in   1               clock, all logic on posedge
//  rst          in   1               synchronous, active-high reset
//  cmd_valid    in   1               producer has a load value
//  cmd_val      in   W               load value to queue
//  cmd_ready    out  1               = !fifo_full (combinational)
//  start        out  1               registered start pulse to timer
//  load_val     out  W               registered, valid while start=1
//  done         in   1               timer done, 1-cycle pulse
//  busy         out  1               state!=IDLE or FIFO non-empty
//  fifo_level   out  $clog2(DEPTH+1) entries currently queued
//  timeout_err  out  1               1-cycle pulse on watchdog abort
//  done_count   out  8               completed commands, wraps 255->0
// BEHAVIOUR
//  Reset (rst sampled high at edge): FIFO flushed, state=IDLE, start=0,
//   load_val=0, timeout_err=0, done_count=0, watchdog=0. Reset wins over all.
//  Enqueue: cmd_valid && cmd_ready at edge -> entry written; level+1.
//   Full: cmd_ready=0, no write, no overwrite. Push+pop same edge: level same.
//  FSM (registered):
//   IDLE : FIFO non-empty -> pop head, start<=1, load_val<=head, ->ISSUE.
//   ISSUE: start high this cycle; start<=0, watchdog<=0, ->WAIT.
//   WAIT : done -> done_count+1, ->GAP. Else watchdog==TIMEOUT-1 ->
//          timeout_err<=1, ->GAP. Else watchdog+1.
//   GAP  : one dead cycle, ->IDLE (timer back to IDLE before next start).
//  Latency: accept at edge k, empty FIFO, IDLE -> start high in cycle after
//   edge k+1. Back-to-back: done at edge d -> next start high after edge d+2.
//  load_val=0 passes unchanged; timer raises done next cycle, handled as normal.
//  done outside WAIT is ignored (no count, no state change).
//  start and done never both high: start only in ISSUE, done only honoured
//   in WAIT; bench asserts this.
//  Reset mid-WAIT: command dropped, no timeout_err, done_count cleared.
//  done_count and fifo_level wrap/saturate rules: done_count mod 256;
//   fifo_level in 0..DEPTH.
// STRUCTURE
//  timer_pkg: seq_state_e {IDLE,ISSUE,WAIT,GAP}, localparam W default.
//  Sub-module timer_cmd_fifo (sync FIFO, DEPTH x W, push/pop/full/empty/level);
//  FSM, watchdog and done_count in top.
// TESTING (bench instantiates sequencer + timer, SVA on start/done)
//  T1 reset: rst=1 two cycles mid-stream -> start=0, fifo_level=0,
//     done_count=0, cmd_ready=1 after reset edge.
//  T2 single cmd 5: push 5 -> start=1,load_val=5 one cycle; timer done after
//     countdown; done_count=1; busy drops one cycle after GAP.
//  T3 burst 10,5,0,3 back-to-back: 4 accepted, 5th held (cmd_ready=0);
//     starts issued in order 10,5,0,3, each exactly 2 cycles after prior done;
//     done_count=4.
//  T4 load 0: push 0 -> start, done next cycle, done_count+1, no timeout_err.
//  T5 timeout: hold timer done low (force) after start -> timeout_err pulse
//     20 cycles after ISSUE, FSM to IDLE, next queued cmd issued.
//  T6 spurious done in IDLE -> ignored, done_count unchanged.

Source files
------------

// File: rtl/timer_cmd_sequencer_pkg.sv
// Shared definitions for the timer command sequencer: parameter defaults and
// the sequencer FSM state encoding.
package timer_cmd_sequencer_pkg;

  localparam int W_DEFAULT       = 4;
  localparam int DEPTH_DEFAULT   = 4;
  localparam int TIMEOUT_DEFAULT = 20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    GAP   = ST_GAP
  } seq_state_e;

endpackage

// File: rtl/timer_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of W bits, first-word fall-through.
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes pointers)
//   push, din         write request and data; ignored while full
//   pop               read request; ignored while empty
//   dout              head entry (valid while !empty)
//   full, empty       occupancy flags
//   level             number of queued entries, 0..DEPTH
module timer_cmd_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [W-1:0]              din,
  input  logic                      pop,
  output logic [W-1:0]              dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign level   = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/timer_cmd_sequencer.sv
// Upstream command stage for the countdown timer. Queues load values from a
// valid/ready producer and issues them one at a time as a single-cycle start
// pulse with load_val, waiting for done (or a watchdog abort) before the next.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid, cmd_val  producer handshake and load value
//   cmd_ready           FIFO not full
//   start, load_val     registered start pulse and value to the timer
//   done                timer completion pulse (honoured only while waiting)
//   busy                command in flight or FIFO non-empty
//   fifo_level          entries queued
//   timeout_err         one-cycle pulse when the watchdog aborts a command
//   done_count          completed commands, modulo 256
module timer_cmd_sequencer
  import timer_cmd_sequencer_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  input  logic [W-1:0]               cmd_val,
  output logic                       cmd_ready,
  output logic                       start,
  output logic [W-1:0]               load_val,
  input  logic                       done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       timeout_err,
  output logic [7:0]                 done_count
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  seq_state_e      state_q, state_d;
  logic            start_q, start_d;
  logic [W-1:0]    load_val_q, load_val_d;
  logic            timeout_err_q, timeout_err_d;
  logic [7:0]      done_count_q, done_count_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [W-1:0]    fifo_head;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  timer_cmd_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (cmd_val),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d       = state_q;
    start_d       = 1'b0;
    load_val_d    = load_val_q;
    timeout_err_d = 1'b0;
    done_count_d  = done_count_q;
    wd_d          = wd_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          start_d    = 1'b1;
          load_val_d = fifo_head;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done) begin
          done_count_d = done_count_q + 8'd1;
          state_d      = GAP;
        end else if (wd_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = GAP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      // One dead cycle lets the timer settle before the next start.
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      load_val_q    <= '0;
      timeout_err_q <= 1'b0;
      done_count_q  <= '0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      load_val_q    <= load_val_d;
      timeout_err_q <= timeout_err_d;
      done_count_q  <= done_count_d;
      wd_q          <= wd_d;
    end
  end

  assign start       = start_q;
  assign load_val    = load_val_q;
  assign timeout_err = timeout_err_q;
  assign done_count  = done_count_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// Bench for timer_cmd_sequencer: the sequencer drives a small countdown timer
// model; random commands, spurious done pulses, masked done (watchdog aborts)
// and resets are applied and every output is compared each cycle against a
// transaction-level reference built on a queue and edge timestamps.
module tb_timer_cmd_sequencer;

  localparam int W       = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic [W-1:0] cmd_val;
  logic         cmd_ready;
  logic         start;
  logic [W-1:0] load_val;
  logic         done;
  logic         busy;
  logic [2:0]   fifo_level;
  logic         timeout_err;
  logic [7:0]   done_count;

  logic         kill;
  logic         spur;
  logic [W-1:0] tmr_cnt;
  logic         tmr_run;
  logic         tmr_done;

  always #5 clk = ~clk;

  timer_cmd_sequencer #(
    .W       (W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_val     (cmd_val),
    .cmd_ready   (cmd_ready),
    .start       (start),
    .load_val    (load_val),
    .done        (done),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .timeout_err (timeout_err),
    .done_count  (done_count)
  );

  // Countdown timer: load 0 reports done the cycle after start.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_cnt  <= '0;
      tmr_run  <= 1'b0;
      tmr_done <= 1'b0;
    end else if (start) begin
      tmr_cnt  <= load_val;
      tmr_run  <= (load_val != 0);
      tmr_done <= (load_val == 0);
    end else if (tmr_run) begin
      tmr_cnt  <= tmr_cnt - 1'b1;
      tmr_done <= (tmr_cnt == 1);
      tmr_run  <= (tmr_cnt != 1);
    end else begin
      tmr_done <= 1'b0;
    end
  end

  assign done = (tmr_done | spur) & ~kill;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending commands in a queue; the command in flight is
  // tracked by the edge at which it was issued, and the earliest edge at
  // which another may issue.
  int mq[$];
  bit m_active;
  int m_issue;
  int m_ready_at;
  bit m_start;
  int m_load;
  bit m_to;
  int m_cnt;
  int n_edge = 0;
  bit kill_state = 1'b0;

  task automatic model_step(input bit r, input bit v, input logic [W-1:0] val, input logic d);
    int sz;
    int el;
    n_edge++;
    if (r) begin
      mq.delete();
      m_active = 0; m_start = 0; m_load = 0; m_to = 0; m_cnt = 0; m_ready_at = 0;
      return;
    end
    sz = mq.size();
    m_start = 0;
    m_to = 0;
    if (!m_active) begin
      if (n_edge >= m_ready_at && sz > 0) begin
        m_load   = mq.pop_front();
        m_start  = 1;
        m_active = 1;
        m_issue  = n_edge;
      end
    end else begin
      el = n_edge - m_issue;
      if (el >= 2) begin
        if (d === 1'b1) begin
          m_cnt      = (m_cnt + 1) % 256;
          m_active   = 0;
          m_ready_at = n_edge + 2;
        end else if (el == TIMEOUT + 1) begin
          m_to       = 1;
          m_active   = 0;
          m_ready_at = n_edge + 2;
        end
      end
    end
    if (v && sz < DEPTH) mq.push_back(int'(val));
  endtask

  task automatic check_outputs();
    int sz;
    sz = mq.size();
    check_val("start",       32'(start),       32'(m_start));
    check_val("load_val",    32'(load_val),    32'(m_load));
    check_val("cmd_ready",   32'(cmd_ready),   32'(sz < DEPTH));
    check_val("fifo_level",  32'(fifo_level),  32'(sz));
    check_val("busy",        32'(busy),        32'(m_active || sz > 0 || (m_ready_at == n_edge + 2)));
    check_val("timeout_err", 32'(timeout_err), 32'(m_to));
    check_val("done_count",  32'(done_count),  32'(m_cnt));
  endtask

  task automatic drive(input bit r, input bit v, input logic [W-1:0] val, input bit k, input bit s);
    logic d;
    rst = r; cmd_valid = v; cmd_val = val; kill = k; spur = s;
    d = (tmr_done | s) & ~k;
    if (!r) check_val("start_done_excl", 32'(start & d), 32'd0);
    model_step(r, v, val, d);
  endtask

  // kill_mode: 0 = done passes, 1 = done masked, 2 = mask toggles randomly
  task automatic run_phase(input int cycles, input int pv, input bit zero_only,
                           input int kill_mode, input int spur_pct, input int rst_pct);
    bit v, s, r;
    logic [W-1:0] val;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_outputs();
      v   = ($urandom_range(99) < pv);
      val = zero_only ? '0 : W'($urandom_range(15));
      r   = ($urandom_range(999) < rst_pct);
      s   = !m_active && ($urandom_range(99) < spur_pct);
      case (kill_mode)
        0:       kill_state = 1'b0;
        1:       kill_state = 1'b1;
        default: if ($urandom_range(99) < 10) kill_state = ~kill_state;
      endcase
      drive(r, v, val, kill_state, s);
    end
  endtask

  initial begin
    drive(1, 0, '0, 0, 0);
    @(negedge clk);
    check_outputs();
    drive(1, 0, '0, 0, 0);
    run_phase(400, 30, 0, 0, 5, 10);   // mixed traffic, spurious done, rare resets
    run_phase(300, 100, 0, 0, 0, 0);   // producer always valid: FIFO fills
    run_phase(400, 20, 0, 1, 0, 0);    // done never arrives: watchdog aborts
    run_phase(1800, 100, 1, 0, 0, 0);  // zero loads, done_count wraps past 255
    run_phase(600, 50, 0, 2, 10, 20);  // everything at once
    run_phase(12, 100, 0, 0, 0, 0);    // stream before a mid-flight reset
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_outputs();
      drive(1, 1, 4'd7, 0, 0);
    end
    run_phase(60, 0, 0, 0, 0, 0);      // quiet after reset
    run_phase(200, 40, 0, 0, 0, 0);
    run_phase(60, 0, 0, 0, 0, 0);      // drain
    @(negedge clk);
    check_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
